// File: rtl/regs_dump_reader.sv
// Walks the register bank through an async read port and streams each register MSB byte first (valid/ready).
// Define REGS_DUMP_CHECKSUM_EN to append an 8-bit XOR checksum byte after the last register.
module regs_dump_reader #(
  parameter int REGISTERS_BANK_SIZE = 32,
  parameter int REGISTERS_SIZE      = 32
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset_n,
  input  logic                                   i_start,
  output logic [$clog2(REGISTERS_BANK_SIZE)-1:0] o_read_register,
  input  logic [REGISTERS_SIZE-1:0]              i_read_data,
  output logic [7:0]                             o_byte_data,
  output logic                                   o_byte_valid,
  input  logic                                   i_byte_ready,
  output logic                                   o_busy,
  output logic                                   o_done
);
  localparam int IDX_W = $clog2(REGISTERS_BANK_SIZE);
  localparam int BYTES = REGISTERS_SIZE / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(REGISTERS_BANK_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

`ifdef REGS_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          index_q;
  logic [REGISTERS_SIZE-1:0] shift_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      xfer;
`ifdef REGS_DUMP_CHECKSUM_EN
  logic [7:0]                csum_q;
`endif

  assign xfer            = o_byte_valid && i_byte_ready;
  assign o_read_register = index_q;
  assign o_busy          = (state_q != IDLE);
  assign o_done          = (state_q == DONE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_start) state_d = LOAD;
      LOAD: state_d = SEND;
      SEND: begin
        if (xfer && (cnt_q == LAST_BYTE)) begin
          if (index_q != LAST_IDX) begin
            state_d = LOAD;
          end else begin
`ifdef REGS_DUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef REGS_DUMP_CHECKSUM_EN
      CSUM: if (xfer) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_byte_valid = 1'b0;
    o_byte_data  = 8'h00;
    if (state_q == SEND) begin
      o_byte_valid = 1'b1;
      o_byte_data  = shift_q[REGISTERS_SIZE-1 -: 8];
    end
`ifdef REGS_DUMP_CHECKSUM_EN
    if (state_q == CSUM) begin
      o_byte_valid = 1'b1;
      o_byte_data  = csum_q;
    end
`endif
  end

  // Datapath: index only advances after the last byte of a register, so the bank read stays stable.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      index_q <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
`ifdef REGS_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      if ((state_q == IDLE) && i_start) begin
        index_q <= '0;
`ifdef REGS_DUMP_CHECKSUM_EN
        csum_q  <= '0;
`endif
      end
      if (state_q == LOAD) begin
        shift_q <= i_read_data;
        cnt_q   <= '0;
      end
      if ((state_q == SEND) && xfer) begin
`ifdef REGS_DUMP_CHECKSUM_EN
        csum_q <= csum_q ^ shift_q[REGISTERS_SIZE-1 -: 8];
`endif
        if (cnt_q != LAST_BYTE) begin
          shift_q <= shift_q << 8;
          cnt_q   <= cnt_q + 1'b1;
        end else if (index_q != LAST_IDX) begin
          index_q <= index_q + 1'b1;
        end
      end
    end
  end
endmodule
